wordle_engine: RTL and testbench
================================

# wordle_engine

Parametrised letter-guessing game engine, the successor to the fixed four-letter game block. It supports a configurable word length and guess budget, with full 26-letter entry and per-position exact/present scoring that handles duplicate letters correctly. The secret word is loaded from a port at the start of each game rather than being hard-wired. The block sits between the board switches/push-button and the seven-segment digits and LEDs.

## Interface
- WORD_LEN, 4: letters per word; 2..8.
- MAX_GUESSES, 6: guesses allowed per game; 1..15.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_n  in  1  enter push-button, active-low, asynchronous to clk.
- letter_i  in  5  letter index (0 = A … 25 = Z); 26..31 are invalid.
- secret_i  in  5*WORD_LEN  secret word; position p occupies bits [5p+4:5p]; position 0 is leftmost.
- seg_o  out  7*WORD_LEN  digit p at [7p+6:7p], segments {a..g}, active-low.
- green_o  out  WORD_LEN  bit p: right letter in the right place.
- yellow_o  out  WORD_LEN  bit p: letter present elsewhere.
- result_valid_o  out  1  one-cycle pulse when green_o/yellow_o update.
- guess_cnt_o  out  $clog2(MAX_GUESSES+1)  number of guesses scored.
- win_o, lose_o  out  1  game-over flags.
- err_o  out  1  one-cycle pulse when a press is rejected.
- busy_o  out  1  high in SCORE_G/SCORE_Y/RESULT.

## Operation
- Reset values: all outputs 0, except seg_o, which is all ones (blank). State is IDLE.
- Press detection:
  - key_n passes through a 2-flop synchroniser.
  - A press is a 1→0 transition of the synchronised value.
  - Presses in SCORE_G, SCORE_Y and RESULT are dropped silently.
- IDLE, on press:
  - If any secret_i letter is ≥26: err_o pulses and the state stays IDLE.
  - Otherwise: latch the secret, clear green/yellow/guess_cnt/win/lose, blank seg_o, set pos=0, go to ENTRY.
- ENTRY, on press:
  - letter_i ≥26: err_o pulses; nothing is stored.
  - Otherwise: store the guess letter at pos and drive digit pos with its glyph.
  - If pos==WORD_LEN-1, go to SCORE_G; else pos++.
- SCORE_G (1 cycle):
  - green[p] = (guess[p]==secret[p]) for all p.
  - Load 26 counters (width $clog2(WORD_LEN+1)) with the occurrences of each secret letter at non-green positions.
- SCORE_Y (WORD_LEN cycles, idx 0..WORD_LEN-1, one position per cycle, left to right):
  - If idx is not green and cnt[guess[idx]]>0: yellow[idx]=1 and decrement that counter.
- RESULT (1 cycle):
  - Drive green_o/yellow_o and pulse result_valid_o.
  - guess_cnt++.
  - All green: win_o=1, seg_o shows the secret, go to WIN.
  - Else if the new guess_cnt==MAX_GUESSES: lose_o=1, seg_o shows the secret, go to LOSE.
  - Else: blank seg_o, pos=0, go to ENTRY. green_o/yellow_o hold until the next RESULT.
- WIN/LOSE, on press: go to IDLE. Flags and display hold until the next game starts.
- When win and budget exhaustion coincide, win takes priority.
- rst_n assertion at any point, including mid-scoring, returns everything to reset values immediately. No partial result is emitted.

## Timing
- If key_n falls before clk edge k, the press action is registered at edge k+2 and outputs change after it.
- Last letter registered at edge t:
  - SCORE_G at t+1.
  - SCORE_Y at t+2 … t+1+WORD_LEN.
  - RESULT outputs valid after edge t+2+WORD_LEN.
  - result_valid_o is high for exactly that one cycle.
- err_o is high for exactly one cycle after the rejecting edge.
- busy_o is high from t+1 through t+2+WORD_LEN (inclusive).
- Glyph decode is combinational from stored letters; no added latency.

## Structure
- Package wordle_pkg holds:
  - LETTER_W=5 and NUM_LETTERS=26.
  - state enum {IDLE, ENTRY, SCORE_G, SCORE_Y, RESULT, WIN, LOSE}.
  - BLANK_SEG=7'h7F.
- Sub-module wordle_glyph: 5-bit letter → 7-bit active-low glyph, instantiated WORD_LEN times. Invalid codes produce BLANK_SEG.
- Synchroniser and edge detect stay inline.

## Test plan
- WORD_LEN=4, secret BITS {1,8,19,18}, guess B,I,T,S → green_o=4'b1111, yellow_o=0, win_o=1, guess_cnt_o=1, seg_o shows BITS.
- Secret BITS, guess S,I,S,T → green_o=4'b0010, yellow_o=4'b1001. The second S is absent (duplicate rule).
- Secret BITS, guess S,S,S,S → green_o=4'b1000, yellow_o=0.
- Letter 27 in ENTRY → err_o pulses one cycle; pos and seg_o are unchanged; a following valid letter lands at the same position.
- MAX_GUESSES=6, six wrong guesses → lose_o=1, guess_cnt_o=6, seg_o shows the secret. The next press returns to IDLE and the one after starts a fresh game with all outputs cleared.
- Assert rst_n in SCORE_Y, and also press key_n during busy_o → reset value on all outputs with no result_valid_o pulse; the press during busy_o is ignored.

Source files
------------

// File: rtl/wordle_pkg.sv
// ---------------------------------------------------------------------------
// wordle_pkg
// Shared types and constants for the letter-guessing game engine.
//   LETTER_W     : bits per letter code (0 = A ... 25 = Z, 26..31 invalid)
//   NUM_LETTERS  : size of the alphabet
//   LETTER_LIMIT : first invalid letter code, at letter width
//   BLANK_SEG    : active-low pattern with every segment off
//   state_t      : game FSM states
// ---------------------------------------------------------------------------
package wordle_pkg;

    localparam int unsigned LETTER_W    = 5;
    localparam int unsigned NUM_LETTERS = 26;

    localparam logic [LETTER_W-1:0] LETTER_LIMIT = LETTER_W'(NUM_LETTERS);
    localparam logic [6:0]          BLANK_SEG    = 7'h7F;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        SCORE_G,
        SCORE_Y,
        RESULT,
        WIN,
        LOSE
    } state_t;

    function automatic logic letter_ok(input logic [LETTER_W-1:0] l);
        return (l < LETTER_LIMIT);
    endfunction

endpackage

// File: rtl/wordle_glyph.sv
// ---------------------------------------------------------------------------
// wordle_glyph
// Letter code to seven-segment glyph, active-low, segment order {a..g}
// with segment a in bit 6. Codes outside the alphabet produce BLANK_SEG.
//   i_letter : letter code
//   o_seg    : active-low segment pattern
// ---------------------------------------------------------------------------
module wordle_glyph
    import wordle_pkg::*;
(
    input  logic [LETTER_W-1:0] i_letter,
    output logic [6:0]          o_seg
);

    always_comb begin
        o_seg = BLANK_SEG;
        case (i_letter)
            5'd0:  o_seg = 7'h08; // A
            5'd1:  o_seg = 7'h60; // b
            5'd2:  o_seg = 7'h31; // C
            5'd3:  o_seg = 7'h42; // d
            5'd4:  o_seg = 7'h30; // E
            5'd5:  o_seg = 7'h38; // F
            5'd6:  o_seg = 7'h21; // G
            5'd7:  o_seg = 7'h48; // H
            5'd8:  o_seg = 7'h79; // I
            5'd9:  o_seg = 7'h43; // J
            5'd10: o_seg = 7'h28; // K
            5'd11: o_seg = 7'h71; // L
            5'd12: o_seg = 7'h2B; // M
            5'd13: o_seg = 7'h6A; // n
            5'd14: o_seg = 7'h62; // o
            5'd15: o_seg = 7'h18; // P
            5'd16: o_seg = 7'h0C; // q
            5'd17: o_seg = 7'h7A; // r
            5'd18: o_seg = 7'h24; // S
            5'd19: o_seg = 7'h70; // t
            5'd20: o_seg = 7'h41; // U
            5'd21: o_seg = 7'h63; // v
            5'd22: o_seg = 7'h55; // W
            5'd23: o_seg = 7'h36; // X
            5'd24: o_seg = 7'h44; // y
            5'd25: o_seg = 7'h12; // Z
            default: o_seg = BLANK_SEG;
        endcase
    end

endmodule

// File: rtl/wordle_engine.sv
// ---------------------------------------------------------------------------
// wordle_engine
// Parametrised letter-guessing game: secret loaded from secret_i at game
// start, guesses entered one letter per press, scored with exact (green)
// and present-elsewhere (yellow) flags with correct duplicate handling.
//   clk, rst_n     : clock, asynchronous active-low reset
//   key_n          : enter push-button, active-low, asynchronous
//   letter_i       : letter code for the current entry
//   secret_i       : secret word, position p at [5p+4:5p]
//   seg_o          : digit p at [7p+6:7p], active-low {a..g}
//   green_o        : per-position exact match
//   yellow_o       : per-position present elsewhere
//   result_valid_o : one-cycle pulse when green_o/yellow_o update
//   guess_cnt_o    : number of guesses scored this game
//   win_o, lose_o  : game-over flags
//   err_o          : one-cycle pulse on a rejected press
//   busy_o         : scoring in progress (SCORE_G/SCORE_Y/RESULT)
// ---------------------------------------------------------------------------
module wordle_engine
    import wordle_pkg::*;
#(
    parameter int unsigned WORD_LEN    = 4,
    parameter int unsigned MAX_GUESSES = 6
)
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               key_n,
    input  logic [LETTER_W-1:0]                letter_i,
    input  logic [LETTER_W*WORD_LEN-1:0]       secret_i,
    output logic [7*WORD_LEN-1:0]              seg_o,
    output logic [WORD_LEN-1:0]                green_o,
    output logic [WORD_LEN-1:0]                yellow_o,
    output logic                               result_valid_o,
    output logic [$clog2(MAX_GUESSES+1)-1:0]   guess_cnt_o,
    output logic                               win_o,
    output logic                               lose_o,
    output logic                               err_o,
    output logic                               busy_o
);

    localparam int unsigned GCW = $clog2(MAX_GUESSES + 1);
    localparam int unsigned CW  = $clog2(WORD_LEN + 1);
    localparam int unsigned IW  = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

    // Press detection
    logic r_key_s1;
    logic r_key_s2;
    logic r_key_d;
    logic w_press;

    // Game state
    state_t              r_state;
    logic [LETTER_W-1:0] r_secret [WORD_LEN];
    logic [LETTER_W-1:0] r_guess  [WORD_LEN];
    logic [LETTER_W-1:0] r_disp   [WORD_LEN];
    logic [IW-1:0]       r_pos;
    logic [IW-1:0]       r_idx;
    logic [WORD_LEN-1:0] r_green_w;
    logic [WORD_LEN-1:0] r_yellow_w;
    logic [CW-1:0]       r_cnt    [NUM_LETTERS];

    // Registered outputs
    logic [WORD_LEN-1:0] r_green;
    logic [WORD_LEN-1:0] r_yellow;
    logic                r_rv;
    logic [GCW-1:0]      r_gcnt;
    logic                r_win;
    logic                r_lose;
    logic                r_err;

    // Combinational helpers
    logic [LETTER_W-1:0] w_sec_in   [WORD_LEN];
    logic                w_secret_ok;
    logic [WORD_LEN-1:0] w_exact;
    logic [CW-1:0]       w_init_cnt [NUM_LETTERS];
    logic [LETTER_W-1:0] w_gidx;
    logic [GCW-1:0]      w_gcnt_next;

    assign w_press = r_key_d & ~r_key_s2;

    always_comb begin
        w_secret_ok = 1'b1;
        for (int unsigned p = 0; p < WORD_LEN; p++) begin
            w_sec_in[p] = secret_i[LETTER_W*p +: LETTER_W];
            if (!letter_ok(w_sec_in[p])) begin
                w_secret_ok = 1'b0;
            end
        end
    end

    // Letter budget for yellows: secret letters not already consumed by a green
    always_comb begin
        for (int unsigned p = 0; p < WORD_LEN; p++) begin
            w_exact[p] = (r_guess[p] == r_secret[p]);
        end
        for (int unsigned l = 0; l < NUM_LETTERS; l++) begin
            w_init_cnt[l] = '0;
            for (int unsigned p = 0; p < WORD_LEN; p++) begin
                if (!w_exact[p] && (r_secret[p] == LETTER_W'(l))) begin
                    w_init_cnt[l] = w_init_cnt[l] + CW'(1);
                end
            end
        end
    end

    assign w_gidx      = r_guess[r_idx];
    assign w_gcnt_next = r_gcnt + GCW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_s1   <= 1'b1;
            r_key_s2   <= 1'b1;
            r_key_d    <= 1'b1;
            r_state    <= IDLE;
            r_secret   <= '{default: '0};
            r_guess    <= '{default: '0};
            r_disp     <= '{default: '1};
            r_pos      <= '0;
            r_idx      <= '0;
            r_green_w  <= '0;
            r_yellow_w <= '0;
            r_cnt      <= '{default: '0};
            r_green    <= '0;
            r_yellow   <= '0;
            r_rv       <= 1'b0;
            r_gcnt     <= '0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_key_s1 <= key_n;
            r_key_s2 <= r_key_s1;
            r_key_d  <= r_key_s2;
            r_err    <= 1'b0;
            r_rv     <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_press) begin
                        if (!w_secret_ok) begin
                            r_err <= 1'b1;
                        end else begin
                            for (int unsigned p = 0; p < WORD_LEN; p++) begin
                                r_secret[p] <= w_sec_in[p];
                                r_disp[p]   <= '1;
                            end
                            r_green  <= '0;
                            r_yellow <= '0;
                            r_gcnt   <= '0;
                            r_win    <= 1'b0;
                            r_lose   <= 1'b0;
                            r_pos    <= '0;
                            r_state  <= ENTRY;
                        end
                    end
                end

                ENTRY: begin
                    if (w_press) begin
                        if (!letter_ok(letter_i)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_guess[r_pos] <= letter_i;
                            r_disp[r_pos]  <= letter_i;
                            if (r_pos == IW'(WORD_LEN - 1)) begin
                                r_state <= SCORE_G;
                            end else begin
                                r_pos <= r_pos + IW'(1);
                            end
                        end
                    end
                end

                SCORE_G: begin
                    r_green_w  <= w_exact;
                    r_yellow_w <= '0;
                    r_cnt      <= w_init_cnt;
                    r_idx      <= '0;
                    r_state    <= SCORE_Y;
                end

                // Left-to-right walk: earlier positions claim a duplicate letter first
                SCORE_Y: begin
                    for (int unsigned l = 0; l < NUM_LETTERS; l++) begin
                        if ((w_gidx == LETTER_W'(l)) && !r_green_w[r_idx] &&
                            (r_cnt[l] != '0)) begin
                            r_yellow_w[r_idx] <= 1'b1;
                            r_cnt[l]          <= r_cnt[l] - CW'(1);
                        end
                    end
                    if (r_idx == IW'(WORD_LEN - 1)) begin
                        r_state <= RESULT;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end

                RESULT: begin
                    r_green  <= r_green_w;
                    r_yellow <= r_yellow_w;
                    r_rv     <= 1'b1;
                    r_gcnt   <= w_gcnt_next;
                    if (&r_green_w) begin
                        r_win   <= 1'b1;
                        r_disp  <= r_secret;
                        r_state <= WIN;
                    end else if (w_gcnt_next == GCW'(MAX_GUESSES)) begin
                        r_lose  <= 1'b1;
                        r_disp  <= r_secret;
                        r_state <= LOSE;
                    end else begin
                        r_disp  <= '{default: '1};
                        r_pos   <= '0;
                        r_state <= ENTRY;
                    end
                end

                WIN, LOSE: begin
                    if (w_press) begin
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < WORD_LEN; g++) begin : g_digit
        wordle_glyph u_glyph (
            .i_letter (r_disp[g]),
            .o_seg    (seg_o[7*g +: 7])
        );
    end

    assign green_o        = r_green;
    assign yellow_o       = r_yellow;
    assign result_valid_o = r_rv;
    assign guess_cnt_o    = r_gcnt;
    assign win_o          = r_win;
    assign lose_o         = r_lose;
    assign err_o          = r_err;
    assign busy_o         = (r_state == SCORE_G) || (r_state == SCORE_Y) ||
                            (r_state == RESULT);

endmodule

// File: tb/tb_wordle_engine.sv
// ---------------------------------------------------------------------------
// tb_wordle_engine
// Directed bench for wordle_engine with WORD_LEN=4, MAX_GUESSES=6 and the
// secret BITS. Expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_wordle_engine;

    localparam logic [19:0] SECRET_BITS = {5'd18, 5'd19, 5'd8, 5'd1};
    localparam logic [19:0] SECRET_BAD  = {5'd18, 5'd27, 5'd8, 5'd1};
    localparam logic [27:0] SEG_BITS    = {7'h24, 7'h70, 7'h79, 7'h60};
    localparam logic [27:0] SEG_BLANK   = 28'hFFFFFFF;

    localparam logic [4:0] L_A = 5'd0;
    localparam logic [4:0] L_B = 5'd1;
    localparam logic [4:0] L_I = 5'd8;
    localparam logic [4:0] L_S = 5'd18;
    localparam logic [4:0] L_T = 5'd19;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_n;
    logic [4:0]  letter_i;
    logic [19:0] secret_i;
    logic [27:0] seg_o;
    logic [3:0]  green_o;
    logic [3:0]  yellow_o;
    logic        result_valid_o;
    logic [2:0]  guess_cnt_o;
    logic        win_o;
    logic        lose_o;
    logic        err_o;
    logic        busy_o;

    int checks      = 0;
    int errors      = 0;
    int err_cycles  = 0;
    int rv_cycles   = 0;
    int e0;
    int r0;

    wordle_engine #(.WORD_LEN(4), .MAX_GUESSES(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_n          (key_n),
        .letter_i       (letter_i),
        .secret_i       (secret_i),
        .seg_o          (seg_o),
        .green_o        (green_o),
        .yellow_o       (yellow_o),
        .result_valid_o (result_valid_o),
        .guess_cnt_o    (guess_cnt_o),
        .win_o          (win_o),
        .lose_o         (lose_o),
        .err_o          (err_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (err_o)          err_cycles++;
        if (result_valid_o) rv_cycles++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [4:0] l);
        letter_i = l;
        key_n    = 1'b0;
        repeat (4) @(negedge clk);
        key_n    = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_result(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, 64'(got), 64'd1);
        @(negedge clk);
        chk({tag, "_pulse_end"}, 64'(result_valid_o), 64'd0);
    endtask

    task automatic guess4(input string tag, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] c, input logic [4:0] d);
        press(a);
        press(b);
        press(c);
        press(d);
        chk({tag, "_busy"}, 64'(busy_o), 64'd1);
        wait_result(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        key_n    = 1'b1;
        letter_i = '0;
        secret_i = SECRET_BITS;
        repeat (3) @(negedge clk);

        chk("rst_seg",    64'(seg_o),          64'(SEG_BLANK));
        chk("rst_green",  64'(green_o),        64'd0);
        chk("rst_yellow", 64'(yellow_o),       64'd0);
        chk("rst_rv",     64'(result_valid_o), 64'd0);
        chk("rst_gcnt",   64'(guess_cnt_o),    64'd0);
        chk("rst_win",    64'(win_o),          64'd0);
        chk("rst_lose",   64'(lose_o),         64'd0);
        chk("rst_err",    64'(err_o),          64'd0);
        chk("rst_busy",   64'(busy_o),         64'd0);

        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Invalid secret rejected in IDLE
        secret_i = SECRET_BAD;
        e0 = err_cycles;
        press(L_A);
        chk("bad_secret_err", 64'(err_cycles - e0), 64'd1);
        chk("bad_secret_seg", 64'(seg_o), 64'(SEG_BLANK));

        // Start with a valid secret; letter 27 on the start press must not err (still IDLE)
        secret_i = SECRET_BITS;
        e0 = err_cycles;
        press(5'd27);
        chk("start_no_err", 64'(err_cycles - e0), 64'd0);
        secret_i = SECRET_BAD;

        // Guess S,I,S,T: duplicate S, second S absent
        guess4("g_sist", L_S, L_I, L_S, L_T);
        chk("sist_green",  64'(green_o),     64'b0010);
        chk("sist_yellow", 64'(yellow_o),    64'b1001);
        chk("sist_gcnt",   64'(guess_cnt_o), 64'd1);
        chk("sist_win",    64'(win_o),       64'd0);
        chk("sist_seg",    64'(seg_o),       64'(SEG_BLANK));

        // Invalid letter in ENTRY, then valid letter lands at position 0
        e0 = err_cycles;
        press(5'd27);
        chk("bad_letter_err", 64'(err_cycles - e0), 64'd1);
        chk("bad_letter_seg", 64'(seg_o), 64'(SEG_BLANK));
        press(L_S);
        chk("pos0_seg", 64'(seg_o), 64'({21'h1FFFFF, 7'h24}));
        press(L_S);
        press(L_S);

        // Final S with a second press landing while busy
        e0 = err_cycles;
        letter_i = L_S;
        key_n    = 1'b0;
        repeat (3) @(negedge clk);
        key_n    = 1'b1;
        @(negedge clk);
        letter_i = L_A;
        key_n    = 1'b0;
        repeat (2) @(negedge clk);
        key_n    = 1'b1;
        repeat (2) @(negedge clk);
        chk("ssss_busy", 64'(busy_o), 64'd1);
        wait_result("g_ssss");
        chk("ssss_green",  64'(green_o),     64'b1000);
        chk("ssss_yellow", 64'(yellow_o),    64'd0);
        chk("ssss_gcnt",   64'(guess_cnt_o), 64'd2);
        repeat (4) @(negedge clk);
        chk("busy_press_seg", 64'(seg_o), 64'(SEG_BLANK));
        chk("busy_press_err", 64'(err_cycles - e0), 64'd0);

        // Winning guess
        guess4("g_bits", L_B, L_I, L_T, L_S);
        chk("win_green",  64'(green_o),     64'b1111);
        chk("win_yellow", 64'(yellow_o),    64'd0);
        chk("win_flag",   64'(win_o),       64'd1);
        chk("win_lose",   64'(lose_o),      64'd0);
        chk("win_gcnt",   64'(guess_cnt_o), 64'd3);
        chk("win_seg",    64'(seg_o),       64'(SEG_BITS));
        chk("win_busy",   64'(busy_o),      64'd0);

        press(L_A);
        chk("win_idle_hold", 64'(win_o), 64'd1);
        chk("win_idle_seg",  64'(seg_o), 64'(SEG_BITS));

        secret_i = SECRET_BITS;
        press(L_A);
        chk("new_green", 64'(green_o),     64'd0);
        chk("new_gcnt",  64'(guess_cnt_o), 64'd0);
        chk("new_win",   64'(win_o),       64'd0);
        chk("new_seg",   64'(seg_o),       64'(SEG_BLANK));

        // Six wrong guesses exhaust the budget
        for (int g = 1; g <= 6; g++) begin
            guess4("g_aaaa", L_A, L_A, L_A, L_A);
            chk("aaaa_gcnt", 64'(guess_cnt_o), 64'(g));
        end
        chk("lose_flag",   64'(lose_o),   64'd1);
        chk("lose_win",    64'(win_o),    64'd0);
        chk("lose_green",  64'(green_o),  64'd0);
        chk("lose_yellow", 64'(yellow_o), 64'd0);
        chk("lose_seg",    64'(seg_o),    64'(SEG_BITS));

        press(L_A);
        chk("lose_idle_hold", 64'(lose_o), 64'd1);
        press(L_A);
        chk("fresh_lose", 64'(lose_o),      64'd0);
        chk("fresh_gcnt", 64'(guess_cnt_o), 64'd0);
        chk("fresh_seg",  64'(seg_o),       64'(SEG_BLANK));

        // Reset in the middle of scoring a would-be winning guess
        guess4("g_sist2", L_S, L_I, L_S, L_T);
        chk("sist2_gcnt", 64'(guess_cnt_o), 64'd1);
        press(L_B);
        press(L_I);
        press(L_T);
        r0 = rv_cycles;
        letter_i = L_S;
        key_n    = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_seg",   64'(seg_o),          64'(SEG_BLANK));
        chk("mid_rst_green", 64'(green_o),        64'd0);
        chk("mid_rst_yel",   64'(yellow_o),       64'd0);
        chk("mid_rst_gcnt",  64'(guess_cnt_o),    64'd0);
        chk("mid_rst_rv",    64'(result_valid_o), 64'd0);
        chk("mid_rst_busy",  64'(busy_o),         64'd0);
        key_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_no_result", 64'(rv_cycles - r0), 64'd0);
        chk("mid_win",       64'(win_o),          64'd0);
        chk("mid_busy_after", 64'(busy_o),        64'd0);
        chk("mid_seg_after", 64'(seg_o),          64'(SEG_BLANK));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
